// File: rtl/wavetable_player.sv
// Streams an address window of a synchronous sample ROM to the left/right codec
// channels, one sample per write strobe, in one-shot or loop mode with per-channel attenuation.
module wavetable_player #(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 17,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [ADDR_W-1:0]  end_addr,
  input  logic [SHIFT_W-1:0] shift_l,
  input  logic [SHIFT_W-1:0] shift_r,
  input  logic               write,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_q,
  output logic [DATA_W-1:0]  writedata_left,
  output logic [DATA_W-1:0]  writedata_right,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         dbg_state
);

  // Handshake: the codec pulses write for one cycle when it has taken the
  // current sample; a write seen while a ROM fetch is in flight is dropped.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_PLAY  = 2'd2
  } state_t;

  state_t              r_state;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_sample;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_start;
  logic [ADDR_W-1:0]   r_end;
  logic                r_loop;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                w_win_ok;

  assign w_win_ok = (end_addr >= start_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_sample <= '0;
      r_addr   <= '0;
      r_start  <= '0;
      r_end    <= '0;
      r_loop   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (stop) begin
        r_state  <= S_IDLE;
        r_sample <= '0;
        r_cnt    <= 2'd0;
        r_busy   <= 1'b0;
      end else if (start && w_win_ok) begin
        r_start <= start_addr;
        r_end   <= end_addr;
        r_loop  <= loop_en;
        r_addr  <= start_addr;
        r_cnt   <= 2'd2;
        r_state <= S_PRIME;
        r_busy  <= 1'b1;
      end else begin
        if (start) r_err <= 1'b1;
        case (r_state)
          S_IDLE: r_sample <= '0;
          S_PRIME: begin
            // ROM registers the address one edge after we do, so data lands on the second edge
            if (r_cnt <= 2'd1) begin
              r_sample <= rom_q;
              r_cnt    <= 2'd0;
              r_state  <= S_PLAY;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
          S_PLAY: begin
            if (r_cnt != 2'd0) begin
              r_cnt <= r_cnt - 2'd1;
              if (r_cnt == 2'd1) r_sample <= rom_q;
            end else if (write) begin
              if (r_addr != r_end) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_cnt  <= 2'd2;
              end else if (r_loop) begin
                r_addr <= r_start;
                r_cnt  <= 2'd2;
              end else begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_sample <= '0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_addr        = r_addr;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign dbg_state       = r_state;
  assign writedata_left  = $signed(r_sample) >>> shift_l;
  assign writedata_right = $signed(r_sample) >>> shift_r;

endmodule
